// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg
// Shared encodings for the multicycle MIPS control path: ALU operation
// codes, the opcode and funct values the controller understands, and the
// FSM state type. Imported by multicycle_ctrl and funct_decode.
package multicycle_ctrl_pkg;

    // ALU operation select codes driven onto ALUOp
    localparam logic [2:0] ALU_OP_ADD = 3'd0;
    localparam logic [2:0] ALU_OP_SUB = 3'd1;
    localparam logic [2:0] ALU_OP_AND = 3'd2;
    localparam logic [2:0] ALU_OP_OR  = 3'd3;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;

    // Controller states; codes 13..15 are unreachable and recover to S_RST
    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEX   = 4'd7,
        S_RTWB   = 4'd8,
        S_BEQ    = 4'd9,
        S_JUMP   = 4'd10,
        S_ITEX   = 4'd11,
        S_ITWB   = 4'd12
    } state_t;

endpackage

// File: rtl/multicycle_ctrl_funct_decode.sv
// funct_decode
// Combinational R-type funct decoder. Maps the funct field to the ALU
// operation and flags whether the funct is one the datapath supports.
// Ports:
//   funct  in  6  instruction[5:0]
//   aluop  out 3  ALU operation for this funct (ADD when unsupported)
//   valid  out 1  1 when funct is addu/subu/and/or
module funct_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] aluop,
    output logic       valid
);

    // Lookup of the four supported R-type functions; anything else is
    // reported invalid so DECODE can take the illegal-instruction path.
    always_comb begin
        aluop = ALU_OP_ADD;
        valid = 1'b0;
        case (funct)
            FUNCT_ADDU: begin aluop = ALU_OP_ADD; valid = 1'b1; end
            FUNCT_SUBU: begin aluop = ALU_OP_SUB; valid = 1'b1; end
            FUNCT_AND:  begin aluop = ALU_OP_AND; valid = 1'b1; end
            FUNCT_OR:   begin aluop = ALU_OP_OR;  valid = 1'b1; end
            default:    begin aluop = ALU_OP_ADD; valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Main control FSM of the multicycle MIPS datapath. Sequences fetch,
// decode, execute, memory and write-back one state per clock and drives
// every datapath control line as a Moore function of state (plus
// opcode/funct, and zero for the PC enable).
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   opcode, funct           fields of the latched instruction
//   zero                    ALU zero flag, used by beq
//   PCEn                    PC load enable = PCWrite | (PCWriteCond & zero)
//   IorD, MemRead, MemWrite memory address select and enables
//   IRWrite                 instruction register load
//   RegDst, MemtoReg, RegWrite  register-file write controls
//   ExtOp                   1 = sign-extend immediate, 0 = zero-extend
//   ALUSrcA, ALUSrcB, ALUOp ALU operand selects and operation
//   PCSource                PC next-value select
//   Illegal, InstrDone      decode-error pulse, end-of-instruction pulse
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ExtOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Illegal,
    output logic       InstrDone
);

    state_t     state;
    state_t     next_state;
    logic       pc_write;
    logic       pc_write_cond;
    logic [2:0] funct_aluop;
    logic       funct_valid;

    funct_decode u_funct_decode (
        .funct (funct),
        .aluop (funct_aluop),
        .valid (funct_valid)
    );

    // The branch decision is taken in the same cycle the ALU compares the
    // operands, so zero feeds the PC enable combinationally.
    assign PCEn = pc_write | (pc_write_cond & zero);

    // State register; reset drops straight into S_RST even mid-instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RST;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode. Every output starts at 0 and each
    // state raises only the lines it needs, so S_RST and any stray code
    // produce an all-quiet datapath.
    always_comb begin
        next_state    = S_RST;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        ExtOp         = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'd0;
        ALUOp         = ALU_OP_ADD;
        PCSource      = 2'd0;
        Illegal       = 1'b0;
        InstrDone     = 1'b0;
        case (state)
            S_RST: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                MemRead    = 1'b1;
                IRWrite    = 1'b1;
                pc_write   = 1'b1;
                ALUSrcB    = 2'd1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively for every opcode
                ALUSrcB = 2'd3;
                ExtOp   = 1'b1;
                case (opcode)
                    OP_LW, OP_SW:     next_state = S_MEMADR;
                    OP_BEQ:           next_state = S_BEQ;
                    OP_J:             next_state = S_JUMP;
                    OP_ADDIU, OP_ORI: next_state = S_ITEX;
                    OP_RTYPE: begin
                        if (funct_valid) begin
                            next_state = S_RTEX;
                        end else begin
                            Illegal    = 1'b1;
                            InstrDone  = 1'b1;
                            next_state = S_FETCH;
                        end
                    end
                    default: begin
                        Illegal    = 1'b1;
                        InstrDone  = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd2;
                ExtOp      = 1'b1;
                next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                InstrDone  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                InstrDone  = 1'b1;
                next_state = S_FETCH;
            end
            S_RTEX: begin
                ALUSrcA    = 1'b1;
                ALUOp      = funct_aluop;
                next_state = S_RTWB;
            end
            S_RTWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                InstrDone  = 1'b1;
                next_state = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALU_OP_SUB;
                pc_write_cond = 1'b1;
                PCSource      = 2'd1;
                InstrDone     = 1'b1;
                next_state    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                PCSource   = 2'd2;
                InstrDone  = 1'b1;
                next_state = S_FETCH;
            end
            S_ITEX: begin
                // ori zero-extends its immediate, addiu sign-extends
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd2;
                ExtOp      = (opcode != OP_ORI);
                ALUOp      = (opcode == OP_ORI) ? ALU_OP_OR : ALU_OP_ADD;
                next_state = S_ITWB;
            end
            S_ITWB: begin
                RegWrite   = 1'b1;
                InstrDone  = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_RST;
            end
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. Sits directly upstream of the ALU: decodes the latched instruction's opcode and funct and sequences fetch, decode, execute, memory and write-back, one state per clock. Each cycle it drives the ALU operation select and operand muxes, memory and register-file enables, and the PC update. It closes the branch loop by consuming the ALU's `zero` flag.

## Interface
Parameters:
- none. Opcode, funct, state and ALU-op encodings come from the shared include.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- funct  in  6  instruction[5:0] from the instruction register.
- zero  in  1  ALU result-is-zero flag, combinational from the ALU.
- PCEn  out  1  PC load enable; equals `PCWrite | (PCWriteCond & zero)`.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut register.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register load enable.
- RegDst  out  1  write register select: 0 = rt, 1 = rd.
- MemtoReg  out  1  write data select: 0 = ALUOut register, 1 = memory data register.
- RegWrite  out  1  register-file write enable.
- ExtOp  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- ALUSrcA  out  1  ALU x operand: 0 = PC, 1 = A register.
- ALUSrcB  out  2  ALU y operand: 0 = B, 1 = constant 4, 2 = extended immediate, 3 = extended immediate << 2.
- ALUOp  out  3  ALU operation select, using the shared `ALU_OP_*` codes.
- PCSource  out  2  PC source: 0 = ALU result, 1 = ALUOut register, 2 = {PC[31:28], instr[25:0], 2'b00}.
- Illegal  out  1  one-cycle pulse in DECODE when the opcode or R-type funct is unsupported.
- InstrDone  out  1  one-cycle pulse in the final state of each instruction.

## Operation
- Moore machine: a 4-bit state register; every output is a pure function of state plus opcode/funct (and `zero` for PCEn).
- Outputs default to 0 in every state except where asserted below.
- RST state: all outputs 0; goes to FETCH unconditionally.
- FETCH:
  - asserts MemRead, IRWrite, PCWrite; IorD = 0.
  - ALU computes PC + 4: ALUSrcA = 0, ALUSrcB = 1, ALUOp = ADD, PCSource = 0.
  - next state DECODE.
- DECODE:
  - ALU precomputes the branch target: ALUSrcA = 0, ALUSrcB = 3, ALUOp = ADD, ExtOp = 1.
  - dispatch on opcode:
    - 6'h23 lw and 6'h2B sw → MEMADR
    - 6'h00 R-type with supported funct → RTEX
    - 6'h04 beq → BEQ
    - 6'h02 j → JUMP
    - 6'h09 addiu and 6'h0D ori → ITEX
    - anything else, or R-type with an unsupported funct → assert Illegal and InstrDone, return to FETCH (executes as a nop).
- MEMADR: ALUSrcA = 1, ALUSrcB = 2, ExtOp = 1, ALUOp = ADD; lw → MEMRD, sw → MEMWR.
- MEMRD: MemRead, IorD = 1; → MEMWB.
- MEMWB: RegWrite, MemtoReg = 1, RegDst = 0, InstrDone; → FETCH.
- MEMWR: MemWrite, IorD = 1, InstrDone; → FETCH.
- RTEX: ALUSrcA = 1, ALUSrcB = 0; ALUOp from funct: 6'h21 → ADD, 6'h23 → SUB, 6'h24 → AND, 6'h25 → OR. → RTWB.
- RTWB: RegWrite, RegDst = 1, MemtoReg = 0, InstrDone; → FETCH.
- BEQ: ALUSrcA = 1, ALUSrcB = 0, ALUOp = SUB, PCWriteCond, PCSource = 1, InstrDone; → FETCH.
- JUMP: PCWrite, PCSource = 2, InstrDone; → FETCH.
- ITEX: ALUSrcA = 1, ALUSrcB = 2; addiu: ExtOp = 1, ALUOp = ADD; ori: ExtOp = 0, ALUOp = OR. → ITWB.
- ITWB: RegWrite, RegDst = 0, MemtoReg = 0, InstrDone; → FETCH.
- Unreachable state encodings go to RST.

## Timing
- Reset:
  - rst high forces RST asynchronously, mid-instruction included; all outputs read 0 during and immediately after reset.
  - first FETCH is the second rising edge after rst falls (RST occupies one cycle).
- Latency in cycles, FETCH to the last state inclusive: lw 5; sw, R-type, addiu, ori 4; beq, j 3; illegal 2.
- opcode/funct must stay stable from DECODE until InstrDone. IR is loaded only in FETCH, so this holds by construction.
- PCEn in BEQ is combinational on `zero` within the same cycle; no registered flag.
- The PC, IR, A, B and ALUOut registers are external and load on the same edge as the FSM.

## Structure
- Shared include (macro.v):
  - `ALU_OP_ADD` = 3'd0, `ALU_OP_SUB` = 3'd1, `ALU_OP_AND` = 3'd2, `ALU_OP_OR` = 3'd3.
  - opcode and funct constants.
  - `S_*` state codes.
- One natural sub-module: `funct_decode`, combinational, funct → {ALUOp, valid}; used by DECODE and RTEX.

## Test plan
- Reset mid-operation: rst pulsed during MEMRD → state RST and all outputs 0 at once; FETCH two edges after release, with MemRead = IRWrite = PCEn = 1.
- lw (opcode 6'h23) → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; InstrDone on cycle 5 only; MemtoReg = 1 with RegWrite.
- R-type funct 6'h23 → ALUOp = 3'd1 in RTEX; RegDst = 1 in RTWB; funct 6'h25 → ALUOp = 3'd3.
- beq with zero = 1 → PCEn = 1 and PCSource = 1 in BEQ; with zero = 0 → PCEn = 0; both back in FETCH next cycle.
- ori → ExtOp = 0, ALUOp = OR, ALUSrcB = 2; addiu → ExtOp = 1, ALUOp = ADD.
- Illegal cases: opcode 6'h3F, and R-type funct 6'h00 → Illegal and InstrDone pulse in DECODE, next state FETCH; RegWrite, MemWrite and PCEn stay 0 throughout.
